ifu_bp_update_ctl: RTL

- Fetch-side consumer of resolved-branch results from the execute ALU stage.
- Takes the per-branch predict-packet update (misp, ataken, hist, BHT index/way) and buffers it in a small coalescing FIFO.
- Drains the FIFO to the BHT write port over a valid/ready handshake.
- Registers the execute-stage branch flush (flush_upper/flush_path) into a one-cycle fetch redirect.

---
 rtl/ifu_bp_update_ctl.sv | 117 +++++++++++
 1 files changed

// File: rtl/ifu_bp_update_ctl.sv
// Resolved-branch BHT update buffer: coalescing FIFO drained over valid/ready, plus registered fetch redirect.
// Optional saturating update statistics when BP_UPDATE_STATS_EN is defined.
module ifu_bp_update_ctl #(
    parameter int IDX_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exu_upd_valid,
    input  logic             exu_upd_misp,
    input  logic             exu_upd_ataken,
    input  logic [1:0]       exu_upd_hist,
    input  logic [IDX_W-1:0] exu_upd_index,
    input  logic             exu_upd_way,
    input  logic             exu_flush_upper,
    input  logic [30:0]      exu_flush_path,
    input  logic             dec_tlu_flush,
    output logic             bht_wr_valid,
    input  logic             bht_wr_ready,
    output logic [IDX_W-1:0] bht_wr_index,
    output logic             bht_wr_way,
    output logic [1:0]       bht_wr_data,
    output logic             ifu_redirect_valid,
    output logic [30:0]      ifu_redirect_pc,
    output logic             upd_fifo_full,
    output logic             upd_drop
`ifdef BP_UPDATE_STATS_EN
    ,
    output logic [31:0]      bp_stat_misp_cnt,
    output logic [31:0]      bp_stat_taken_cnt,
    output logic [15:0]      bp_stat_drop_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             way;
        logic [1:0]       hist;
    } upd_ent_t;

    upd_ent_t        mem [DEPTH];
    logic [PW:0]     wr_ptr, rd_ptr;
    logic [PW:0]     occ;
    logic [PW-1:0]   tail_idx;
    logic            empty, full, pop, coalesce, alloc, drop;
    upd_ent_t        new_ent, head;

    assign occ      = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign tail_idx = wr_ptr[PW-1:0] - PW'(1);
    assign pop      = ~empty & bht_wr_ready;
    assign new_ent  = '{index: exu_upd_index, way: exu_upd_way, hist: exu_upd_hist};

    // The head is either being popped or stalled on the handshake, so it is never
    // merged into: only a newest entry that is not also the head may coalesce.
    assign coalesce = exu_upd_valid && (occ > (PW+1)'(1)) &&
                      (mem[tail_idx].index == exu_upd_index) && (mem[tail_idx].way == exu_upd_way);
    assign alloc    = exu_upd_valid & ~coalesce & (~full | pop);
    assign drop     = exu_upd_valid & ~coalesce & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (coalesce) mem[tail_idx].hist <= exu_upd_hist;
            if (alloc) begin
                mem[wr_ptr[PW-1:0]] <= new_ent;
                wr_ptr              <= wr_ptr + (PW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    assign head          = mem[rd_ptr[PW-1:0]];
    assign bht_wr_valid  = ~empty;
    assign bht_wr_index  = head.index;
    assign bht_wr_way    = head.way;
    assign bht_wr_data   = head.hist;
    assign upd_fifo_full = full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_drop           <= 1'b0;
            ifu_redirect_valid <= 1'b0;
            ifu_redirect_pc    <= '0;
        end else begin
            upd_drop           <= drop;
            ifu_redirect_valid <= exu_flush_upper & ~dec_tlu_flush;
            if (exu_flush_upper & ~dec_tlu_flush) ifu_redirect_pc <= exu_flush_path;
        end
    end

`ifdef BP_UPDATE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_stat_misp_cnt  <= '0;
            bp_stat_taken_cnt <= '0;
            bp_stat_drop_cnt  <= '0;
        end else begin
            if (exu_upd_valid && exu_upd_misp && !drop && bp_stat_misp_cnt != '1)
                bp_stat_misp_cnt <= bp_stat_misp_cnt + 32'd1;
            if (exu_upd_valid && exu_upd_ataken && bp_stat_taken_cnt != '1)
                bp_stat_taken_cnt <= bp_stat_taken_cnt + 32'd1;
            if (upd_drop && bp_stat_drop_cnt != '1)
                bp_stat_drop_cnt <= bp_stat_drop_cnt + 16'd1;
        end
    end
`else
    logic unused_stat_in;
    assign unused_stat_in = exu_upd_misp ^ exu_upd_ataken;
`endif

endmodule
